// File: rtl/jw_nmea_ram_writer_if.sv
// jw_nmea_ram_writer_if: UART byte stream in, jw RAM write port and status out
//   rx_valid/rx_data          byte strobe and ASCII byte from the UART receiver
//   jw_ram_we/addr/data       16x8 jw RAM write port
//   fix_valid/frame_done      last sentence status 'A' / pulse after a burst
interface jw_nmea_ram_writer_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       jw_ram_we;
  logic [3:0] jw_ram_addr;
  logic [7:0] jw_ram_data;
  logic       fix_valid;
  logic       frame_done;
  modport master (output rx_valid, rx_data,
                  input jw_ram_we, jw_ram_addr, jw_ram_data, fix_valid, frame_done);
  modport slave (input rx_valid, rx_data,
                 output jw_ram_we, jw_ram_addr, jw_ram_data, fix_valid, frame_done);
endinterface

// File: rtl/jw_nmea_ram_writer.sv
// jw_nmea_ram_writer: parse $GPRMC/$GNRMC lat/lon into a 16-byte shadow and burst it into the jw RAM
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of jw_nmea_ram_writer_if (rx stream in, RAM write port and status out)
module jw_nmea_ram_writer #(
  parameter logic [7:0] BLANK_CODE  = 8'h0F,
  parameter int          HDR_TIMEOUT = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  jw_nmea_ram_writer_if.slave bus
);
  if (HDR_TIMEOUT != 0) begin : g_bad_timeout
    $error("HDR_TIMEOUT must be 0");
  end
  typedef enum logic [1:0] {IDLE, HDR, FIELD, WRITE} state_t;
  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [2:0] field_q, field_d;
  logic [7:0] status_q, status_d;
  logic [7:0] shadow_q [16];
  logic [7:0] shadow_d [16];
  logic       we_q, we_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       fix_q, fix_d;
  logic       done_q, done_d;
  logic       bad;
  logic       is_dig;
  logic [7:0] dig;
  logic [7:0] hdr_c;
  assign is_dig = bus.rx_data >= "0" && bus.rx_data <= "9";
  assign dig    = bus.rx_data - "0";
  assign hdr_c  = idx_q == 4'd0 ? "G" : idx_q == 4'd1 ? "P" : idx_q == 4'd2 ? "R" :
                  idx_q == 4'd3 ? "M" : idx_q == 4'd4 ? "C" : ",";
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    field_d  = field_q;
    status_d = status_q;
    shadow_d = shadow_q;
    we_d     = 1'b0;
    addr_d   = 4'd0;
    data_d   = data_q;
    fix_d    = fix_q;
    done_d   = 1'b0;
    bad      = 1'b0;
    if (state_q == WRITE) begin
      we_d    = addr_q != 4'd15;
      addr_d  = we_d ? addr_q + 4'd1 : 4'd0;
      data_d  = we_d ? shadow_q[addr_q + 4'd1] : data_q;
      done_d  = !we_d;
      fix_d   = fix_q | !we_d;
      state_d = we_d ? WRITE : IDLE;
    end else if (bus.rx_valid) begin
      if (bus.rx_data == "$") begin
        state_d  = HDR;
        idx_d    = 4'd0;
        field_d  = 3'd0;
        status_d = 8'h00;
        shadow_d = '{default: BLANK_CODE};
      end else if (state_q == HDR) begin
        // the second header letter may be P (GPS) or N (multi-GNSS)
        if (bus.rx_data == hdr_c || (idx_q == 4'd1 && bus.rx_data == "N")) begin
          idx_d   = idx_q == 4'd5 ? 4'd0 : idx_q + 4'd1;
          field_d = idx_q == 4'd5 ? 3'd1 : field_q;
          state_d = idx_q == 4'd5 ? FIELD : HDR;
        end else begin
          state_d = IDLE;
        end
      end else if (state_q == FIELD) begin
        if (bus.rx_data == ",") begin
          idx_d   = 4'd0;
          field_d = field_q + 3'd1;
          if (field_q == 3'd6) begin
            state_d = status_q == "A" ? WRITE : IDLE;
            fix_d   = status_q == "A" ? fix_q : 1'b0;
            we_d    = status_q == "A";
            data_d  = status_q == "A" ? shadow_q[0] : data_q;
          end
        end else begin
          idx_d = idx_q == 4'd15 ? 4'd15 : idx_q + 4'd1;
          // a rejected byte may leave junk in the shadow; it is re-blanked by the next '$'
          case (field_q)
            3'd2: status_d = idx_q == 4'd0 ? bus.rx_data : status_q;
            3'd3: begin
              if (idx_q < 4'd4) begin
                shadow_d[idx_q + 4'd1] = dig;
                bad = !is_dig;
              end else if (idx_q == 4'd4) begin
                bad = bus.rx_data != ".";
              end else if (idx_q < 4'd8) begin
                shadow_d[idx_q] = dig;
                bad = !is_dig;
              end
            end
            3'd4: if (idx_q == 4'd0) begin
              shadow_d[0] = bus.rx_data == "N" ? 8'h0A : 8'h0B;
              bad = bus.rx_data != "N" && bus.rx_data != "S";
            end
            3'd5: begin
              if (idx_q < 4'd5) begin
                shadow_d[idx_q + 4'd9] = dig;
                bad = !is_dig;
              end else if (idx_q == 4'd5) begin
                bad = bus.rx_data != ".";
              end else if (idx_q < 4'd8) begin
                shadow_d[idx_q + 4'd8] = dig;
                bad = !is_dig;
              end
            end
            3'd6: if (idx_q == 4'd0) begin
              shadow_d[8] = bus.rx_data == "E" ? 8'h0C : 8'h0D;
              bad = bus.rx_data != "E" && bus.rx_data != "W";
            end
            default: ;
          endcase
          state_d = bad ? IDLE : FIELD;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      field_q  <= 3'd0;
      status_q <= 8'h00;
      shadow_q <= '{default: BLANK_CODE};
      we_q     <= 1'b0;
      addr_q   <= 4'd0;
      data_q   <= 8'h00;
      fix_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      field_q  <= field_d;
      status_q <= status_d;
      shadow_q <= shadow_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      fix_q    <= fix_d;
      done_q   <= done_d;
    end
  end
  assign bus.jw_ram_we   = we_q;
  assign bus.jw_ram_addr = addr_q;
  assign bus.jw_ram_data = data_q;
  assign bus.fix_valid   = fix_q;
  assign bus.frame_done  = done_q;
endmodule

// File: tb/tb_jw_nmea_ram_writer.sv
// tb_jw_nmea_ram_writer: directed sentences with hand-computed RAM images
module tb_jw_nmea_ram_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;
  int dn = 0;
  int dn_cyc = 0;
  logic [3:0] wa [$];
  logic [7:0] wd [$];
  int wcyc [$];
  localparam logic [7:0] EXP1 [16] = '{8'h0A, 8'h04, 8'h08, 8'h00, 8'h07, 8'h00, 8'h03, 8'h08,
                                       8'h0C, 8'h00, 8'h01, 8'h01, 8'h03, 8'h01, 8'h00, 8'h00};
  localparam logic [7:0] EXP2 [16] = '{8'h0B, 8'h03, 8'h03, 8'h04, 8'h05, 8'h01, 8'h02, 8'h03,
                                       8'h0D, 8'h01, 8'h05, 8'h01, 8'h01, 8'h02, 8'h09, 8'h08};
  localparam string S1 = "$GPRMC,123519,A,4807.0381,N,01131.0002,E,";
  jw_nmea_ram_writer_if bus ();
  jw_nmea_ram_writer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (bus.jw_ram_we === 1'b1) begin
      wa.push_back(bus.jw_ram_addr);
      wd.push_back(bus.jw_ram_data);
      wcyc.push_back(cyc);
    end
    if (bus.frame_done === 1'b1) begin
      dn++;
      dn_cyc = cyc;
    end
  end
  task send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = s[i];
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
  endtask
  task test_reset;
    ncmp++;
    if (bus.jw_ram_we !== 1'b0 || bus.jw_ram_addr !== 4'd0 || bus.jw_ram_data !== 8'h00 ||
        bus.fix_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
      nerr++;
      $display("FAIL reset: we=%b addr=%h data=%h fix=%b done=%b, need all 0",
               bus.jw_ram_we, bus.jw_ram_addr, bus.jw_ram_data, bus.fix_valid, bus.frame_done);
    end
  endtask
  task test_basic;
    int n0, d0;
    n0 = wa.size();
    d0 = dn;
    send_str(S1);
    ncmp++;
    if (bus.jw_ram_we !== 1'b1 || bus.jw_ram_addr !== 4'd0 || bus.jw_ram_data !== 8'h0A) begin
      nerr++;
      $display("FAIL basic_latency: we=%b addr=%h data=%h, need 1/0/0a",
               bus.jw_ram_we, bus.jw_ram_addr, bus.jw_ram_data);
    end
    repeat (20) @(negedge clk);
    #1;
    ncmp++;
    if (wa.size() - n0 != 16) begin
      nerr++;
      $display("FAIL basic_count: got %0d writes, need 16", wa.size() - n0);
    end
    for (int i = 0; i < 16 && n0 + i < wa.size(); i++) begin
      ncmp++;
      if (wa[n0+i] !== 4'(i) || wd[n0+i] !== EXP1[i]) begin
        nerr++;
        $display("FAIL basic_write%0d: addr=%h data=%h, need addr=%h data=%h", i, wa[n0+i], wd[n0+i], 4'(i), EXP1[i]);
      end
      ncmp++;
      if (wcyc[n0+i] != wcyc[n0] + i) begin
        nerr++;
        $display("FAIL basic_consecutive%0d: cycle %0d, need %0d", i, wcyc[n0+i], wcyc[n0] + i);
      end
    end
    ncmp++;
    if (dn - d0 != 1 || wa.size() < n0 + 16 || dn_cyc != wcyc[n0+15] + 1) begin
      nerr++;
      $display("FAIL basic_done: pulses=%0d at cycle %0d, need 1 right after last write", dn - d0, dn_cyc);
    end
    ncmp++;
    if (bus.fix_valid !== 1'b1) begin
      nerr++;
      $display("FAIL basic_fix: fix_valid=%b, need 1", bus.fix_valid);
    end
  endtask
  task test_void;
    int n0, d0;
    n0 = wa.size();
    d0 = dn;
    send_str("$GPRMC,123519,V,4807.0381,N,01131.0002,E,");
    repeat (20) @(negedge clk);
    #1;
    ncmp++;
    if (wa.size() != n0 || dn != d0) begin
      nerr++;
      $display("FAIL void_nowrite: writes=%0d done=%0d, need 0/0", wa.size() - n0, dn - d0);
    end
    ncmp++;
    if (bus.fix_valid !== 1'b0) begin
      nerr++;
      $display("FAIL void_fix: fix_valid=%b, need 0", bus.fix_valid);
    end
  endtask
  task test_no_strobe;
    int n0;
    n0 = wa.size();
    for (int i = 0; i < S1.len(); i++) begin
      bus.rx_data = S1[i];
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    #1;
    ncmp++;
    if (wa.size() != n0) begin
      nerr++;
      $display("FAIL no_strobe: writes=%0d, need 0", wa.size() - n0);
    end
  endtask
  task test_blank;
    int n0;
    n0 = wa.size();
    send_str("$GNRMC,,A,,,,,$GPRMC,1,A,1111.1111,N,");
    repeat (20) @(negedge clk);
    #1;
    ncmp++;
    if (wa.size() - n0 != 16) begin
      nerr++;
      $display("FAIL blank_count: got %0d writes, need 16", wa.size() - n0);
    end
    for (int i = 0; i < 16 && n0 + i < wa.size(); i++) begin
      ncmp++;
      if (wa[n0+i] !== 4'(i) || wd[n0+i] !== 8'h0F) begin
        nerr++;
        $display("FAIL blank_write%0d: addr=%h data=%h, need addr=%h data=0f", i, wa[n0+i], wd[n0+i], 4'(i));
      end
    end
    ncmp++;
    if (bus.fix_valid !== 1'b1) begin
      nerr++;
      $display("FAIL blank_fix: fix_valid=%b, need 1", bus.fix_valid);
    end
  endtask
  task test_bad_lat;
    int n0, d0;
    n0 = wa.size();
    d0 = dn;
    send_str("$GPRMC,123519,A,48x7.0381,N,01131.0002,E,");
    repeat (20) @(negedge clk);
    #1;
    ncmp++;
    if (wa.size() != n0 || dn != d0 || bus.fix_valid !== 1'b1) begin
      nerr++;
      $display("FAIL badlat_nowrite: writes=%0d done=%0d fix=%b, need 0/0/1", wa.size() - n0, dn - d0, bus.fix_valid);
    end
    send_str(S1);
    repeat (20) @(negedge clk);
    #1;
    ncmp++;
    if (wa.size() - n0 != 16) begin
      nerr++;
      $display("FAIL badlat_recover_count: got %0d writes, need 16", wa.size() - n0);
    end
    for (int i = 0; i < 16 && n0 + i < wa.size(); i++) begin
      ncmp++;
      if (wd[n0+i] !== EXP1[i]) begin
        nerr++;
        $display("FAIL badlat_recover%0d: data=%h, need %h", i, wd[n0+i], EXP1[i]);
      end
    end
  endtask
  task test_restart;
    int n0, d0;
    n0 = wa.size();
    d0 = dn;
    send_str("$GPRMC,123519,A,4807.0381,N,011$GNRMC,000000,A,3345.1234,S,15112.9876,W,");
    repeat (20) @(negedge clk);
    #1;
    ncmp++;
    if (wa.size() - n0 != 16 || dn - d0 != 1) begin
      nerr++;
      $display("FAIL restart_count: got %0d writes %0d done, need 16/1", wa.size() - n0, dn - d0);
    end
    for (int i = 0; i < 16 && n0 + i < wa.size(); i++) begin
      ncmp++;
      if (wa[n0+i] !== 4'(i) || wd[n0+i] !== EXP2[i]) begin
        nerr++;
        $display("FAIL restart_write%0d: addr=%h data=%h, need addr=%h data=%h", i, wa[n0+i], wd[n0+i], 4'(i), EXP2[i]);
      end
    end
  endtask
  task test_mid_burst_reset;
    int n0, d0;
    n0 = wa.size();
    d0 = dn;
    send_str(S1);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    ncmp++;
    if (bus.jw_ram_we !== 1'b0 || bus.jw_ram_addr !== 4'd0 || bus.jw_ram_data !== 8'h00 ||
        bus.fix_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
      nerr++;
      $display("FAIL midreset_outputs: we=%b addr=%h data=%h fix=%b done=%b, need all 0",
               bus.jw_ram_we, bus.jw_ram_addr, bus.jw_ram_data, bus.fix_valid, bus.frame_done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    ncmp++;
    if (wa.size() - n0 != 5 || dn != d0) begin
      nerr++;
      $display("FAIL midreset_count: writes=%0d done=%0d, need 5/0", wa.size() - n0, dn - d0);
    end
  endtask
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_void();
    test_no_strobe();
    test_blank();
    test_bad_lat();
    test_restart();
    test_mid_burst_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/jw_nmea_ram_writer.md
Name: jw_nmea_ram_writer

Overview:
Producer side of the 16x8 latitude/longitude (jw) display RAM. Parses the NMEA $GPRMC/$GNRMC sentence from the GPS UART byte stream and extracts latitude, longitude and hemispheres into a 16-byte shadow buffer. When the fix is valid, it burst-writes all 16 entries into the jw RAM write port (we/addr/data), where the little-digit display reads them.

Parameters:
BLANK_CODE, 8'h0F, code written for a missing or blank digit
HDR_TIMEOUT, 0, reserved; must be 0 (no timeout logic)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_valid  input  1  one-cycle strobe; rx_data holds a received byte
rx_data  input  8  ASCII byte from UART receiver
jw_ram_we  output  1  RAM write enable
jw_ram_addr  output  4  RAM write address
jw_ram_data  output  8  RAM write data
fix_valid  output  1  high after the last sentence had status 'A'
frame_done  output  1  one-cycle pulse on the cycle after the last burst write

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; jw_ram_we=0, jw_ram_addr=0, jw_ram_data=0, fix_valid=0, frame_done=0.
  - All 16 shadow bytes are set to BLANK_CODE.
- RAM layout (digits are raw 0-9, not ASCII):
  - Addr 0: lat hemisphere, N=0x0A, S=0x0B.
  - Addr 1-2: lat degrees. Addr 3-4: lat minutes. Addr 5-7: first 3 decimal-minute digits.
  - Addr 8: lon hemisphere, E=0x0C, W=0x0D.
  - Addr 9-11: lon degrees. Addr 12-13: lon minutes. Addr 14-15: first 2 decimal-minute digits.
- Only cycles with rx_valid=1 advance the parser; bytes arriving while rx_valid=0 are never used.
- States:
  - IDLE: wait for '$'. On '$': char index=0, field=0, all shadow bytes reset to BLANK_CODE, go to HDR.
  - HDR: match "G", {'P'|'N'}, "R", "M", "C", ",". Any mismatch goes to IDLE. Full match goes to FIELD with field=1.
  - FIELD: ',' increments field and clears the char index. The char index saturates at 15.
    - Field 1 (time): skipped.
    - Field 2: first char is latched as status.
    - Field 3 (lat, "ddmm.mmmm"): index 0-3 go to addr 1-4; index 4 must be '.'; index 5-7 go to addr 5-7; index >7 ignored.
    - Field 4: 'N' or 'S' goes to addr 0.
    - Field 5 (lon, "dddmm.mmmm"): index 0-4 go to addr 9-13; index 5 must be '.'; index 6-7 go to addr 14-15.
    - Field 6: 'E' or 'W' goes to addr 8.
    - A digit position holding a non-digit, a wrong '.', or an illegal hemisphere letter goes to IDLE with no write and fix_valid unchanged.
    - '$' in HDR or FIELD restarts the parse exactly as in IDLE.
  - The comma that ends field 6:
    - Status 'A': go to WRITE.
    - Any other status: fix_valid<=0, go to IDLE, no RAM write.
    - Empty fields leave BLANK_CODE in their slots.
  - WRITE: 16 consecutive cycles with jw_ram_we=1, addr 0..15, data = shadow[addr], registered outputs.
    - rx bytes during WRITE are ignored, including '$'.
    - Next cycle: jw_ram_we=0, frame_done=1 for 1 cycle, fix_valid<=1, go to IDLE.
- Latency: first write occurs 1 cycle after the field-6-terminating comma is accepted; the burst takes exactly 16 cycles.
- Outside WRITE: jw_ram_we=0, jw_ram_addr holds 0, jw_ram_data holds its last value.
- Reset mid-burst: stop immediately; the RAM keeps any partially written entries.

Test Plan:
- "$GPRMC,123519,A,4807.0381,N,01131.0002,E,..." -> 16 writes, data 0A,4,8,0,7,0,3,8,0C,0,1,1,3,1,0,0 at addr 0-15; then frame_done pulses and fix_valid=1.
- Same sentence with status 'V' -> no jw_ram_we; fix_valid becomes 0.
- "$GNRMC,,A,,,,," -> 16 writes, all 0x0F; fix_valid=1.
- Latitude "48x7.0381" -> no write; parser returns to IDLE; the next valid sentence writes correctly.
- '$' injected mid-longitude, then a full valid sentence -> exactly one burst, carrying the second sentence's values.
- rst_n pulled low at the 5th write cycle -> jw_ram_we=0 immediately; all outputs return to reset values; no frame_done pulse.
